// File: rtl/alu_muldiv.sv
// Registered RV32 ALU with iterative shift-add multiply and restoring divide.
// Optional feature macro: ALU_MULDIV_EN (when undefined, all 1xxxx opcodes are illegal).
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [4:0]      CTRL,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            FLUSH,
  output logic [XLEN-1:0] OUT,
  output logic            OUT_VALID,
  output logic            ILLEGAL,
  output logic            BUSY
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] r_out;
  logic            r_valid;
  logic            r_ill;
  logic [XLEN-1:0] w_base_res;
  logic            w_base_ill;
  logic [SHW-1:0]  w_shamt;
  logic            w_accept;

  assign w_shamt   = B[SHW-1:0];
  assign OUT       = r_out;
  assign OUT_VALID = r_valid;
  assign ILLEGAL   = r_ill;

  always_comb begin
    w_base_res = '0;
    w_base_ill = 1'b0;
    case (CTRL)
      5'b00000: w_base_res = A + B;
      5'b00001: w_base_res = A - B;
      5'b00010: w_base_res = A << w_shamt;
      5'b00011: w_base_res = A >> w_shamt;
      5'b00100: w_base_res = $signed(A) >>> w_shamt;
      5'b00101: w_base_res = A & B;
      5'b00110: w_base_res = A | B;
      5'b00111: w_base_res = A ^ B;
      5'b01000: w_base_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
      5'b01001: w_base_res = {{(XLEN-1){1'b0}}, A < B};
      default:  w_base_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

  state_t            r_state;
  logic [SHW-1:0]    r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_oper;
  logic [2:0]        r_op;
  logic              r_neg;
  logic              r_rneg;

  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_done_res;

  assign IN_READY = (r_state == S_IDLE);
  assign BUSY     = (r_state != S_IDLE);
  assign w_accept = IN_VALID & IN_READY & ~FLUSH;

  // MUL/MULH sign both operands, MULHSU only A, MULHU neither; DIV/REM both.
  assign w_is_div   = CTRL[2];
  assign w_a_signed = w_is_div ? ~CTRL[0] : (CTRL[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~CTRL[0] : ~CTRL[1];
  assign w_a_neg    = A[XLEN-1] & w_a_signed;
  assign w_b_neg    = B[XLEN-1] & w_b_signed;
  assign w_a_mag    = w_a_neg ? -A : A;
  assign w_b_mag    = w_b_neg ? -B : B;

  assign w_div_zero = (B == '0);
  assign w_div_ovf  = ~CTRL[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (&B);
  assign w_special  = CTRL[4] & w_is_div & (w_div_zero | w_div_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = CTRL[1] ? A : '1;
    else if (w_div_ovf)
      w_special_res = CTRL[1] ? '0 : A;
  end

  // Multiply: low half holds the multiplier and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_oper};
  assign w_mul_next = r_prod[0] ? {w_mul_sum, r_prod[XLEN-1:1]}
                                : {1'b0, r_prod[2*XLEN-1:1]};

  // Divide: high half is the partial remainder, low half the dividend/quotient.
  assign w_div_trial = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]} - {1'b0, r_oper};
  assign w_div_next  = w_div_trial[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};

  assign w_prod_fin = r_neg  ? -r_prod : r_prod;
  assign w_quo      = r_neg  ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
  assign w_rem      = r_rneg ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];

  always_comb begin
    if (r_op[2])
      w_done_res = r_op[1] ? w_rem : w_quo;
    else if (r_op == 3'b000)
      w_done_res = w_prod_fin[XLEN-1:0];
    else
      w_done_res = w_prod_fin[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_oper  <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (CTRL[4] && !w_special) begin
              r_op    <= CTRL[2:0];
              r_neg   <= w_a_neg ^ w_b_neg;
              r_rneg  <= w_a_neg;
              r_cnt   <= '0;
              r_oper  <= w_is_div ? w_b_mag : w_a_mag;
              r_prod  <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_state <= w_is_div ? S_DIV : S_MUL;
            end else begin
              r_out   <= CTRL[4] ? w_special_res : w_base_res;
              r_ill   <= CTRL[4] ? 1'b0 : w_base_ill;
              r_valid <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (FLUSH) begin
            r_state <= S_IDLE;
          end else begin
            r_prod <= (r_state == S_MUL) ? w_mul_next : w_div_next;
            if (r_cnt == LAST_STEP)
              r_state <= S_DONE;
            else
              r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (!FLUSH) begin
            r_out   <= w_done_res;
            r_ill   <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`else

  assign IN_READY = 1'b1;
  assign BUSY     = 1'b0;
  assign w_accept = IN_VALID & ~FLUSH;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_out   <= w_base_res;
        r_ill   <= w_base_ill;
        r_valid <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered successor of the single-cycle integer ALU for the pipelined RV32 core. It executes the base ALU operations with a fixed one-cycle latency and the RV32M multiply/divide operations on an iterative shift-add / restoring-divide datapath. A valid/ready request handshake, a result-valid pulse and a BUSY flag let the EX stage stall around multi-cycle operations.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN): derived shift-amount width; not overridable.

- CLK  in  1  rising-edge clock.
- RESETN  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  request present.
- IN_READY  out  1  block can accept a request; high only in IDLE.
- CTRL  in  5  opcode, sampled on accept.
- A, B  in  XLEN  operands, sampled on accept.
- FLUSH  in  1  synchronous abort of any in-flight operation.
- OUT  out  XLEN  result; held until the next result.
- OUT_VALID  out  1  one-cycle pulse when OUT updates.
- ILLEGAL  out  1  qualifies OUT_VALID: opcode was unsupported.
- BUSY  out  1  high whenever state ≠ IDLE.

## Operation
- Accept occurs on a rising edge where IN_VALID & IN_READY.
- Base opcodes, bit 4 = 0: 00000 ADD, 00001 SUB, 00010 SLL, 00011 SRL, 00100 SRA, 00101 AND, 00110 OR, 00111 XOR, 01000 SLT, 01001 SLTU.
- M opcodes, bit 4 = 1, low 3 bits = RV funct3: 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Shifts use only B[SHW-1:0].
- SLT is a signed compare; SLTU is an unsigned compare. The result is zero-extended 0 or 1.
- Any other opcode completes as a base op with OUT = 0 and ILLEGAL = 1.
- States are IDLE, MUL, DIV and DONE.
  - IDLE: on accept of a base, illegal or special-case op, compute the result and register it directly (remain in IDLE).
  - IDLE: on accept of MUL*, latch the operand magnitudes and the negate flag, clear the count, and go to MUL.
  - IDLE: on accept of DIV*/REM*, do the same and go to DIV.
- MUL: one shift-add step per cycle into a 2·XLEN product. After XLEN steps go to DONE.
- DIV: one restoring step per cycle, producing quotient and remainder. After XLEN steps go to DONE.
- DONE: apply sign correction, select the result word, register OUT, pulse OUT_VALID, and go to IDLE.
- Result selection:
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
  - Signed multiply operands are converted to magnitudes; the product is negated when the operand signs differ.
  - The quotient sign is sign(A) XOR sign(B). The remainder takes the sign of A.
- Special cases, resolved at accept with 1-cycle latency:
  - Divide by zero: quotient = all ones, remainder = A.
  - Signed overflow (A = −2^(XLEN−1), B = −1): quotient = A, remainder = 0.
- FLUSH:
  - In MUL/DIV/DONE: return to IDLE next edge, no OUT_VALID, OUT unchanged.
  - With IN_VALID in IDLE: the request is dropped.
  - FLUSH has priority over accept.
- Reset values: OUT = 0, OUT_VALID = 0, ILLEGAL = 0, state = IDLE (so BUSY = 0, IN_READY = 1). Count and datapath registers are 0.
- Reset mid-operation discards the operation immediately (asynchronous).

## Timing
- Latency is counted from the accepting edge E.
- Base, illegal and special-case ops: OUT_VALID high in the cycle after E.
- MUL*/DIV*/REM*: XLEN step edges, then the DONE edge. OUT_VALID is high in the cycle after edge E+XLEN+1, which is 34 cycles for XLEN = 32.
- Back-to-back base ops: one per cycle; IN_READY stays high.
- A new request may be accepted in the same cycle OUT_VALID is high for a prior result.
- BUSY rises the cycle after a multi-cycle accept. It falls in the cycle OUT_VALID pulses.
- There is no output backpressure. The consumer must capture OUT on OUT_VALID; OUT holds afterwards.
- All outputs are registered. IN_READY is decoded from state only (no input-to-output combinational path).

## Configuration
- ALU_MULDIV_EN defined: full behaviour as above, including the MUL and DIV states.
- ALU_MULDIV_EN undefined:
  - MUL/DIV datapath, count and those states are removed.
  - All 1xxxx opcodes behave as illegal: OUT = 0, ILLEGAL = 1, 1-cycle latency.
  - BUSY is tied to 0 and IN_READY to 1.

## Test plan
- Reset: RESETN low, then release → OUT = 0, OUT_VALID = 0, BUSY = 0, IN_READY = 1.
- Base-op stream: SUB 5,7 → 0xFFFFFFFE. SRA 0x80000000,0x24 → 0xF8000000 (shamt 4). SLTU 1,0xFFFFFFFF → 1. Results appear on consecutive cycles, each with 1-cycle latency.
- Multiply: MULH 0xFFFFFFFF,0xFFFFFFFF → 0. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF,2 → 0xFFFFFFFF. Each pulses OUT_VALID 34 cycles after accept, with BUSY high in between.
- Divide: DIV −7,2 → −3. REM −7,2 → −1. DIVU 7,0 → 0xFFFFFFFF (1 cycle). DIV 0x80000000,−1 → 0x80000000 (1 cycle).
- Abort: FLUSH 10 cycles into a DIVU → no OUT_VALID, OUT unchanged, IN_READY high next cycle. RESETN pulsed mid-MUL → outputs return to reset values at once.
- Illegal: CTRL = 01111 → OUT = 0 with ILLEGAL = 1 after 1 cycle. With ALU_MULDIV_EN undefined, CTRL = 10000 → the same.
